// File: rtl/bcd_disp_pkg.sv
// Shared constants and helpers for the BCD up/down counter and its 7-segment display.
package bcd_disp_pkg;

  // Active-low patterns, bit 0 = segment a .. bit 6 = segment g.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  function automatic logic [3:0] bcd_step(input logic [3:0] d, input logic up);
    if (up) return (d == 4'd9) ? 4'd0 : d + 4'd1;
    return (d == 4'd0) ? 4'd9 : d - 4'd1;
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the up/down counter; load has priority over counting.
module bcd_digit
  import bcd_disp_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       up,
  input  logic       load,
  input  logic [3:0] d,
  output logic [3:0] q,
  output logic       carry_out,
  output logic       borrow_out
);

  always_ff @(posedge clk) begin
    if (reset)     q <= 4'd0;
    else if (load) q <= clamp_bcd(d);
    else if (en)   q <= bcd_step(q, up);
  end

  // Indicates this digit rolls over on its next enabled step in the current direction.
  assign carry_out  = up & (q == 4'd9);
  assign borrow_out = ~up & (q == 4'd0);

endmodule

// File: rtl/bcd_updown_counter_display.sv
// N-digit BCD up/down counter with manual/auto stepping and a multiplexed 7-segment driver.
module bcd_updown_counter_display
  import bcd_disp_pkg::*;
#(
  parameter int NDIGITS  = 4,
  parameter int CLK_HZ   = 50_000_000,
  parameter int AUTO_HZ  = 10,
  parameter int SCAN_HZ  = 1000,
  parameter int BLANK_LZ = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pulso,
  input  logic                   auto_mode,
  input  logic                   up,
  input  logic                   wrap_en,
  input  logic                   load,
  input  logic [4*NDIGITS-1:0]   load_val,
  output logic [4*NDIGITS-1:0]   count,
  output logic                   at_limit,
  output logic [NDIGITS-1:0]     an,
  output logic [6:0]             segs
);

  localparam int TICK_DIV = CLK_HZ / AUTO_HZ;
  localparam int SLOT_DIV = CLK_HZ / (SCAN_HZ * NDIGITS);
  localparam int TW = cnt_width(TICK_DIV);
  localparam int SW = cnt_width(SLOT_DIV);
  localparam int IW = cnt_width(NDIGITS);
  localparam logic [4*NDIGITS-1:0] ALL9 = {NDIGITS{4'h9}};

  logic sync1, sync2, sync3, step;
  logic [TW-1:0] tdiv;
  logic tick, ev, ev_eff, at_end;
  logic [NDIGITS-1:0] cy, bw, chain, blank;
  logic [4*NDIGITS-1:0] cnt_next;
  logic [SW-1:0] sdiv;
  logic [IW-1:0] idx;
  logic scan_pulse, upper_zero, acc;
  logic [3:0] cur_digit;
  logic [6:0] seg_dec;

  always_ff @(posedge clk) begin
    if (reset) {sync3, sync2, sync1} <= 3'b000;
    else       {sync3, sync2, sync1} <= {sync2, sync1, pulso};
  end
  assign step = sync2 & ~sync3;

  // Held at zero outside auto mode so the first tick is a full period after entry.
  always_ff @(posedge clk) begin
    if (reset || !auto_mode)            tdiv <= '0;
    else if (tdiv == TW'(TICK_DIV - 1)) tdiv <= '0;
    else                                tdiv <= tdiv + TW'(1);
  end
  assign tick = auto_mode && (tdiv == TW'(TICK_DIV - 1));
  assign ev   = auto_mode ? tick : step;

  always_comb begin
    acc   = 1'b1;
    chain = '0;
    for (int k = 0; k < NDIGITS; k++) begin
      chain[k] = acc;
      acc      = acc & (cy[k] | bw[k]);
    end
    at_end = acc;
  end
  assign ev_eff = ev & (wrap_en | ~at_end);

  for (genvar k = 0; k < NDIGITS; k++) begin : g_digit
    bcd_digit u_digit (
      .clk        (clk),
      .reset      (reset),
      .en         (ev_eff & chain[k]),
      .up         (up),
      .load       (load),
      .d          (load_val[4*k +: 4]),
      .q          (count[4*k +: 4]),
      .carry_out  (cy[k]),
      .borrow_out (bw[k])
    );
  end

  // Mirror of the value the digits take on this edge, used only for the limit flag.
  always_comb begin
    cnt_next = count;
    for (int k = 0; k < NDIGITS; k++) begin
      if (load)                   cnt_next[4*k +: 4] = clamp_bcd(load_val[4*k +: 4]);
      else if (ev_eff && chain[k]) cnt_next[4*k +: 4] = bcd_step(count[4*k +: 4], up);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) at_limit <= 1'b0;
    else       at_limit <= up ? (cnt_next == ALL9) : (cnt_next == '0);
  end

  assign scan_pulse = (sdiv == SW'(SLOT_DIV - 1));
  always_ff @(posedge clk) begin
    if (reset) begin
      sdiv <= '0;
      idx  <= '0;
    end else if (scan_pulse) begin
      sdiv <= '0;
      idx  <= (idx == IW'(NDIGITS - 1)) ? '0 : idx + IW'(1);
    end else begin
      sdiv <= sdiv + SW'(1);
    end
  end

  always_comb begin
    blank      = '0;
    upper_zero = 1'b1;
    for (int k = NDIGITS - 1; k > 0; k--) begin
      upper_zero = upper_zero & (count[4*k +: 4] == 4'd0);
      blank[k]   = (BLANK_LZ != 0) & upper_zero;
    end
  end

  assign cur_digit = count[4*int'(idx) +: 4];
  always_comb begin
    seg_dec = SEG_BLANK;
    case (cur_digit)
      4'd0:    seg_dec = SEG_0;
      4'd1:    seg_dec = SEG_1;
      4'd2:    seg_dec = SEG_2;
      4'd3:    seg_dec = SEG_3;
      4'd4:    seg_dec = SEG_4;
      4'd5:    seg_dec = SEG_5;
      4'd6:    seg_dec = SEG_6;
      4'd7:    seg_dec = SEG_7;
      4'd8:    seg_dec = SEG_8;
      4'd9:    seg_dec = SEG_9;
      default: seg_dec = SEG_BLANK;
    endcase
  end

  // Enables and segments share one register stage so a digit never shows its neighbour's pattern.
  always_ff @(posedge clk) begin
    if (reset) begin
      an   <= '1;
      segs <= SEG_BLANK;
    end else begin
      an   <= ~(NDIGITS'(1) << idx);
      segs <= blank[idx] ? SEG_BLANK : seg_dec;
    end
  end

endmodule
